// File: rtl/tlk2711_tx_pattern_gen_pkg.sv
// rtl/tlk2711_tx_pattern_gen_pkg.sv - shared TX pattern constants, FSM states and pattern step
package tlk2711_tx_pattern_gen_pkg;

    localparam logic [2:0]  TX_MODE_BURST     = 3'd3;
    localparam int          TEST_WORDS_DFLT   = 435;
    localparam int          BURST_WORDS_DFLT  = 5376;
    localparam logic [15:0] PATTERN_SEED      = 16'h0001;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_GAP,
        ST_DONE
    } state_e;

    // Each byte advances by 2 independently; no carry between bytes.
    function automatic logic [15:0] next_pattern(input logic [15:0] w);
        return {w[15:8] + 8'd2, w[7:0] + 8'd2};
    endfunction

endpackage

// File: rtl/tlk2711_tx_pattern_gen.sv
// rtl/tlk2711_tx_pattern_gen.sv - incrementing-byte frame source for the TLK2711 TX FIFO
module tlk2711_tx_pattern_gen
    import tlk2711_tx_pattern_gen_pkg::*;
#(
    parameter int TEST_WORDS  = TEST_WORDS_DFLT,
    parameter int BURST_WORDS = BURST_WORDS_DFLT,
    parameter int DW          = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_soft_rst,
    input  logic          i_tx_start,
    input  logic [2:0]    i_tx_mode,
    input  logic [15:0]   i_frame_num,
    input  logic [15:0]   i_gap_cycles,
    input  logic          i_ready,
    output logic          o_valid,
    output logic [DW-1:0] o_data,
    output logic          o_sof,
    output logic          o_eof,
    output logic          o_busy,
    output logic          o_done,
    output logic [15:0]   o_frame_cnt
);

    localparam logic [15:0] TEST_LAST  = 16'(TEST_WORDS - 1);
    localparam logic [15:0] BURST_LAST = 16'(BURST_WORDS - 1);

    state_e      state_q;
    logic        start_r_q;
    logic [15:0] last_idx_q;
    logic [15:0] nframes_q;
    logic [15:0] gap_q;
    logic [15:0] word_cnt_q;
    logic [15:0] gap_cnt_q;
    logic [15:0] frame_cnt_q;
    logic        valid_q;
    logic [15:0] data_q;
    logic        sof_q;
    logic        eof_q;
    logic        busy_q;
    logic        done_q;

    logic        tx_start_p;
    logic        xfer;
    logic [15:0] word_cnt_d;
    logic [15:0] frame_cnt_d;

    assign tx_start_p  = i_tx_start & ~start_r_q;
    assign xfer        = valid_q & i_ready;
    assign word_cnt_d  = word_cnt_q + 16'd1;
    assign frame_cnt_d = frame_cnt_q + 16'd1;

    always_ff @(posedge clk) begin
        if (rst || i_soft_rst) begin
            state_q     <= ST_IDLE;
            // Held high start across reset must drop before it can trigger a run.
            start_r_q   <= 1'b1;
            last_idx_q  <= TEST_LAST;
            nframes_q   <= 16'd1;
            gap_q       <= 16'd0;
            word_cnt_q  <= 16'd0;
            gap_cnt_q   <= 16'd0;
            frame_cnt_q <= 16'd0;
            valid_q     <= 1'b0;
            data_q      <= PATTERN_SEED;
            sof_q       <= 1'b0;
            eof_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            start_r_q <= i_tx_start;
            done_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (tx_start_p) begin
                        state_q <= ST_LOAD;
                        busy_q  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    last_idx_q  <= (i_tx_mode == TX_MODE_BURST) ? BURST_LAST : TEST_LAST;
                    nframes_q   <= (i_frame_num == 16'd0) ? 16'd1 : i_frame_num;
                    gap_q       <= i_gap_cycles;
                    frame_cnt_q <= 16'd0;
                    word_cnt_q  <= 16'd0;
                    data_q      <= PATTERN_SEED;
                    sof_q       <= 1'b1;
                    eof_q       <= 1'b0;
                    valid_q     <= 1'b1;
                    state_q     <= ST_RUN;
                end
                ST_RUN: begin
                    if (xfer) begin
                        if (eof_q) begin
                            frame_cnt_q <= frame_cnt_d;
                            word_cnt_q  <= 16'd0;
                            data_q      <= PATTERN_SEED;
                            eof_q       <= 1'b0;
                            if (frame_cnt_d == nframes_q) begin
                                valid_q <= 1'b0;
                                sof_q   <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= ST_DONE;
                            end else if (gap_q == 16'd0) begin
                                sof_q   <= 1'b1;
                            end else begin
                                valid_q   <= 1'b0;
                                sof_q     <= 1'b0;
                                gap_cnt_q <= 16'd0;
                                state_q   <= ST_GAP;
                            end
                        end else begin
                            word_cnt_q <= word_cnt_d;
                            data_q     <= next_pattern(data_q);
                            sof_q      <= 1'b0;
                            eof_q      <= (word_cnt_d == last_idx_q);
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_q == gap_q - 16'd1) begin
                        valid_q <= 1'b1;
                        sof_q   <= 1'b1;
                        state_q <= ST_RUN;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 16'd1;
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_valid     = valid_q;
    assign o_data      = data_q;
    assign o_sof       = sof_q;
    assign o_eof       = eof_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_frame_cnt = frame_cnt_q;

endmodule
